// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: one 4-bit lookahead adder is reused once per slice,
// least-significant slice first, to add two W-bit operands plus a carry-in.
// A valid/ready handshake accepts operands and holds the result until the
// consumer takes it.

// 4-bit adder. Carries are formed from generate/propagate terms, so every
// carry depends only on the inputs and the slice carry-in.
module ripple_carry_lookahead_adder (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g = a & b;
   assign p = a ^ b;

   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);

   assign sum  = p ^ c[3:0];
   assign cout = c[4];

endmodule

module nibble_serial_adder #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   input  logic                   cin,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*NIBBLES-1:0]   sum,
   output logic                   cout
);

   localparam int W  = 4 * NIBBLES;
   localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CW-1:0] LAST_SLICE = CW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_reg;
   state_t          state_next;

   logic [W-1:0]    a_reg;
   logic [W-1:0]    b_reg;
   logic [W-1:0]    sum_reg;
   logic            carry_reg;
   logic            cout_reg;
   logic [CW-1:0]   cnt_reg;

   logic [3:0]      a_nib [NIBBLES];
   logic [3:0]      b_nib [NIBBLES];
   logic [3:0]      slice_a;
   logic [3:0]      slice_b;
   logic [3:0]      slice_sum;
   logic            slice_cout;
   logic            last_slice;

   // Split the captured operands into nibble lanes for the slice mux.
   generate
      for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
         assign a_nib[gi] = a_reg[4*gi +: 4];
         assign b_nib[gi] = b_reg[4*gi +: 4];
      end
   endgenerate

   assign slice_a    = a_nib[cnt_reg];
   assign slice_b    = b_nib[cnt_reg];
   assign last_slice = (cnt_reg == LAST_SLICE);

   ripple_carry_lookahead_adder u_slice_adder (
      .a    (slice_a),
      .b    (slice_b),
      .cin  (carry_reg),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   // State register; reset drops straight back to IDLE, aborting any operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state and handshake outputs; no accept in the handoff cycle.
   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = ADD;
            end
         end
         ADD: begin
            if (last_slice) begin
               state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath: capture operands on accept, then one slice per cycle in ADD.
   // The counter parks on the last slice rather than wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg     <= '0;
         b_reg     <= '0;
         sum_reg   <= '0;
         carry_reg <= 1'b0;
         cout_reg  <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  a_reg     <= a;
                  b_reg     <= b;
                  carry_reg <= cin;
                  cout_reg  <= 1'b0;
                  cnt_reg   <= '0;
               end
            end
            ADD: begin
               sum_reg[4*cnt_reg +: 4] <= slice_sum;
               carry_reg               <= slice_cout;
               if (last_slice) begin
                  cout_reg <= slice_cout;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign sum  = sum_reg;
   assign cout = cout_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder (NIBBLES=4): vector table, random vectors,
// backpressure, operand disturbance after accept and asynchronous reset abort.
// Expected results go into a scoreboard queue when operands are driven.
module tb_nibble_serial_adder;

   localparam int N = 4;
   localparam int W = 4 * N;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          cin;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  sum;
   logic          cout;

   int tests = 0;
   int fails = 0;

   logic [W:0] sb_q[$];

   typedef struct {
      logic [W-1:0] va;
      logic [W-1:0] vb;
      logic         vcin;
      logic [W-1:0] esum;
      logic         ecout;
      int           hold;
   } vec_t;

   vec_t vecs[8];

   nibble_serial_adder #(.NIBBLES(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tc,
                          input logic [W-1:0] es, input logic ec, input int hold, input string tag);
      logic [W:0] exp;
      int edges;
      @(negedge clk);
      check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
      a = ta; b = tbv; cin = tc; in_valid = 1'b1;
      sb_q.push_back({ec, es});
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      // Disturb operands, keep in_valid high, poke out_ready early: all ignored.
      a = 16'hFFFF; b = W'($urandom); cin = ~tc; in_valid = 1'b1; out_ready = 1'b1;
      while (!out_valid && edges < 40) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      out_ready = 1'b0;
      check({tag, " latency"}, 32'(edges), 32'(N + 1));
      if (sb_q.size() == 0) begin
         check({tag, " scoreboard empty"}, 32'd0, 32'd1);
         exp = '0;
      end else begin
         exp = sb_q[0];
      end
      for (int i = 0; i < hold; i++) begin
         in_valid = i[0];
         @(posedge clk);
         @(negedge clk);
         check({tag, " hold {valid,ready,cout,sum}"}, {13'd0, out_valid, in_ready, cout, sum},
               {13'd0, 1'b1, 1'b0, exp});
      end
      in_valid = 1'b0;
      if (sb_q.size() != 0) begin
         exp = sb_q.pop_front();
      end
      check({tag, " sum"}, 32'(sum), 32'(exp[W-1:0]));
      check({tag, " cout"}, 32'(cout), 32'(exp[W]));
      $display("[TB] %s a=%h b=%h cin=%0d -> sum=%h cout=%0d lat=%0d", tag, ta, tbv, tc, sum, cout, edges);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, " back to idle"}, {30'd0, out_valid, in_ready}, 32'b01);
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      logic [W:0]   m;

      vecs[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0};
      vecs[2] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 0};
      vecs[3] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 10};
      vecs[4] = '{16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 0};
      vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 0};
      vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 0};
      vecs[7] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 3};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
      #1;
      check("reset {valid,ready,cout,sum}", {13'd0, out_valid, in_ready, cout, sum}, {13'd0, 2'b01, 17'd0});
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         run_txn(vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].esum, vecs[i].ecout,
                 vecs[i].hold, $sformatf("vec%0d", i));
      end

      for (int i = 0; i < 6; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
         m  = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
         run_txn(ra, rb, rc, m[W-1:0], m[W], i % 2, $sformatf("rnd%0d", i));
      end

      // Reset mid-ADD after slice 1: partial result must vanish at once.
      @(negedge clk);
      a = 16'h5555; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("partial sum before reset", 32'(sum[7:0]), 32'h77);
      #2 rst = 1'b1;
      #1;
      check("async reset {valid,ready,cout,sum}", {13'd0, out_valid, in_ready, cout, sum}, {13'd0, 2'b01, 17'd0});
      $display("[TB] reset mid-ADD: out_valid=%0d in_ready=%0d sum=%h cout=%0d", out_valid, in_ready, sum, cout);
      @(posedge clk);
      #2 rst = 1'b0;
      run_txn(16'h0003, 16'h0003, 1'b0, 16'h0006, 1'b0, 0, "post_reset");

      check("scoreboard drained", 32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 Parameter NIBBLES, default 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 2..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  operand set presented.
REQ-005 in_ready  output  1  block accepts an operand set this cycle.
REQ-006 a  input  W  operand A.
REQ-007 b  input  W  operand B.
REQ-008 cin  input  1  carry-in to slice 0.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 sum  output  W  registered result.
REQ-012 cout  output  1  carry-out of the top slice.

Function
REQ-013 The block SHALL instantiate exactly one ripple_carry_lookahead_adder (4-bit A, B, Cin; Sum, Cout) and reuse it once per slice, least-significant slice first.
REQ-014 FSM states SHALL be IDLE, ADD, DONE; reset state IDLE.
REQ-015 IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready, capture a, b, cin into internal registers, clear slice counter to 0, go to ADD.
REQ-016 ADD: in_ready=0, out_valid=0; each cycle feed adder with nibble[cnt] of captured a and b and the carry register (captured cin for cnt=0).
REQ-017 ADD: each cycle write adder Sum into sum[4*cnt+3:4*cnt], load carry register with adder Cout, increment cnt.
REQ-018 ADD exits to DONE on the cycle cnt==NIBBLES-1 is processed; cout SHALL take that cycle's adder Cout.
REQ-019 Latency: acceptance edge to out_valid=1 SHALL be exactly NIBBLES+1 rising edges; no bubbles between slices.
REQ-020 DONE: out_valid=1, in_ready=0; sum and cout SHALL stay stable until out_valid&&out_ready.
REQ-021 DONE with out_ready=1: return to IDLE next edge; new operands SHALL NOT be accepted in the same cycle as result handoff (no overlap).
REQ-022 in_valid during ADD or DONE SHALL be ignored; a, b, cin changes after acceptance SHALL NOT affect the result.
REQ-023 Arithmetic: {cout, sum} SHALL equal a + b + cin modulo 2^(W+1), unsigned; all-ones overflow wraps sum to 0 with cout=1.
REQ-024 Slice counter width SHALL be ceil(log2(NIBBLES)) minimum; it SHALL NOT wrap beyond NIBBLES-1 within ADD.
REQ-025 out_ready asserted while out_valid=0 SHALL have no effect.

Reset
REQ-026 rst asserted SHALL immediately (without clock) force state IDLE, in_ready=1, out_valid=0, sum=0, cout=0, cnt=0, carry register=0, captured operands=0.
REQ-027 rst asserted mid-ADD or in DONE SHALL abort the operation; the partial result SHALL NOT appear on out_valid after release.
REQ-028 First operand acceptance SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-029 NIBBLES=4, a=0x0000, b=0x0000, cin=0 -> after 5 edges out_valid=1, sum=0x0000, cout=0.
REQ-030 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry ripples through all four slices).
REQ-031 a=0xAAAA, b=0x5555, cin=1 -> sum=0x0000, cout=1; a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0.
REQ-032 Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid, sum, cout constant, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-033 Operand change after accept: accept a=0x0F0F, b=0x0101, then drive a=0xFFFF during ADD -> sum=0x1010, cout=0.
REQ-034 Reset mid-ADD (after slice 1) -> outputs zero asynchronously, in_ready=1; next transaction a=0x0003, b=0x0003, cin=0 -> sum=0x0006, cout=0.
